chrominance_upsampling: RTL and testbench

//  Decoder-side counterpart of 4:2:0 chroma downsampling. Takes one 8x8 downsampled Cb/Cr block pair
//  (2x2-replicated format) and rebuilds full-resolution 8x8 Cb/Cr planes, one output row per cycle.

---
 rtl/chrominance_upsampling_if.sv | 26 ++
 rtl/chrominance_upsampling.sv | 145 ++++++++++++++
 tb/tb_chrominance_upsampling.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chrominance_upsampling_if.sv
// Block-level bus for chrominance_upsampling: input block handshake,
// the downsampled Cb/Cr planes, the rebuilt planes and the output handshake.
// The DUT side uses the slave modport, the producer/consumer side the master.
interface chrominance_upsampling_if #(
  parameter int PIX_W = 8,
  parameter int BLK   = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic [BLK*BLK*PIX_W-1:0]   Cb_d;
  logic [BLK*BLK*PIX_W-1:0]   Cr_d;
  logic [BLK*BLK*PIX_W-1:0]   Cb_u;
  logic [BLK*BLK*PIX_W-1:0]   Cr_u;
  logic                       out_valid;
  logic                       out_ready;

  modport master (
    output in_valid, Cb_d, Cr_d, out_ready,
    input  in_ready, Cb_u, Cr_u, out_valid
  );

  modport slave (
    input  in_valid, Cb_d, Cr_d, out_ready,
    output in_ready, Cb_u, Cr_u, out_valid
  );
endinterface

// File: rtl/chrominance_upsampling.sv
// chrominance_upsampling: rebuilds full-resolution 8x8 Cb/Cr planes from a
// 2x2-replicated 4:2:0 block pair, one output row per enabled cycle.
// Build option: define BILINEAR_INTERP_EN for separable 3:1 bilinear
// interpolation; otherwise nearest-neighbour (exact inverse of replication).
// Flow: IDLE (capture 4x4 samples) -> COMPUTE (8 rows) -> DONE (hold until taken).
module chrominance_upsampling #(
  parameter int PIX_W = 8,
  parameter int BLK   = 8
) (
  input  logic                      Clock,
  input  logic                      reset,
  input  logic                      Enable,
  chrominance_upsampling_if.slave   bus
);

  localparam int SUB   = BLK / 2;
  localparam int VEC   = BLK * BLK * PIX_W;
  localparam int SVEC  = SUB * SUB * PIX_W;
  localparam int RW    = $clog2(BLK);
  localparam int ACC_W = PIX_W + 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [RW-1:0]      row_q, row_d;
  logic [SVEC-1:0]    cb_s_q, cb_s_d;
  logic [SVEC-1:0]    cr_s_q, cr_s_d;
  logic [VEC-1:0]     cb_u_q, cb_u_d;
  logic [VEC-1:0]     cr_u_q, cr_u_d;

  // Sample (a,b) of the captured 4x4 grid.
  function automatic logic [PIX_W-1:0] samp(input logic [SVEC-1:0] s, input int a, input int b);
    return s[(a*SUB + b)*PIX_W +: PIX_W];
  endfunction

  // Output pixel (r,c) computed from the captured grid.
  function automatic logic [PIX_W-1:0] out_pix(input logic [SVEC-1:0] s, input int r, input int c);
`ifdef BILINEAR_INTERP_EN
    int sr, sc, nr, nc;
    logic [ACC_W-1:0] acc;
    sr = r >> 1;
    sc = c >> 1;
    // Neighbour lies on the side of the sample that this output pixel is nearer to.
    nr = ((r & 1) == 0) ? sr - 1 : sr + 1;
    nc = ((c & 1) == 0) ? sc - 1 : sc + 1;
    if (nr < 0) nr = 0;
    else if (nr > SUB - 1) nr = SUB - 1;
    else nr = nr;
    if (nc < 0) nc = 0;
    else if (nc > SUB - 1) nc = SUB - 1;
    else nc = nc;
    // Weights sum to 16, so the rounded result never exceeds the sample range.
    acc = ACC_W'(samp(s, sr, sc)) * ACC_W'(9)
        + ACC_W'(samp(s, sr, nc)) * ACC_W'(3)
        + ACC_W'(samp(s, nr, sc)) * ACC_W'(3)
        + ACC_W'(samp(s, nr, nc))
        + ACC_W'(8);
    return acc[ACC_W-1:4];
`else
    return samp(s, r >> 1, c >> 1);
`endif
  endfunction

  // Next-state, capture and row-generation logic; everything holds when Enable is low.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cb_s_d  = cb_s_q;
    cr_s_d  = cr_s_q;
    cb_u_d  = cb_u_q;
    cr_u_d  = cr_u_q;
    if (Enable) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            // Only the even/even pixel of each 2x2 cell carries information.
            for (int a = 0; a < SUB; a++) begin
              for (int b = 0; b < SUB; b++) begin
                cb_s_d[(a*SUB + b)*PIX_W +: PIX_W] = bus.Cb_d[((2*a)*BLK + 2*b)*PIX_W +: PIX_W];
                cr_s_d[(a*SUB + b)*PIX_W +: PIX_W] = bus.Cr_d[((2*a)*BLK + 2*b)*PIX_W +: PIX_W];
              end
            end
            row_d   = '0;
            state_d = ST_COMPUTE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_COMPUTE: begin
          for (int c = 0; c < BLK; c++) begin
            cb_u_d[(int'(row_q)*BLK + c)*PIX_W +: PIX_W] = out_pix(cb_s_q, int'(row_q), c);
            cr_u_d[(int'(row_q)*BLK + c)*PIX_W +: PIX_W] = out_pix(cr_s_q, int'(row_q), c);
          end
          row_d = row_q + RW'(1);
          if (row_q == RW'(BLK - 1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_COMPUTE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State, row counter, sample grids and output planes; reset discards any partial block.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      cb_s_q  <= '0;
      cr_s_q  <= '0;
      cb_u_q  <= '0;
      cr_u_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cb_s_q  <= cb_s_d;
      cr_s_q  <= cr_s_d;
      cb_u_q  <= cb_u_d;
      cr_u_q  <= cr_u_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.Cb_u      = cb_u_q;
  assign bus.Cr_u      = cr_u_q;

endmodule

// File: tb/tb_chrominance_upsampling.sv
// Self-checking bench for chrominance_upsampling: directed scenarios plus
// randomized blocks with random Enable/out_ready, checked against a
// pixel-level reference model of the upsampling rules.
module tb_chrominance_upsampling;

  localparam int VW = 512;

  logic Clock  = 1'b0;
  logic reset  = 1'b0;
  logic Enable = 1'b0;

  chrominance_upsampling_if u_if ();

  chrominance_upsampling u_dut (
    .Clock  (Clock),
    .reset  (reset),
    .Enable (Enable),
    .bus    (u_if)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  bit rand_mode = 1'b0;

  // reference-model state
  bit             busy = 1'b0;
  bit             got_valid = 1'b0;
  int             en_cnt = 0;
  logic [VW-1:0]  exp_cb = '0;
  logic [VW-1:0]  exp_cr = '0;

  task automatic chk_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < VW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference: pick the sample grid S[a][b]=pix(2a,2b) and rebuild each pixel.
  function automatic logic [VW-1:0] model(input logic [VW-1:0] d);
    logic [VW-1:0] o;
    int s [4][4];
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        s[a][b] = int'(d[((2*a)*8 + 2*b)*8 +: 8]);
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        int v;
`ifdef BILINEAR_INTERP_EN
        int sr, sc, nr, nc;
        sr = r / 2;
        sc = c / 2;
        nr = (r % 2 == 0) ? sr - 1 : sr + 1;
        nc = (c % 2 == 0) ? sc - 1 : sc + 1;
        if (nr < 0) nr = 0;
        if (nr > 3) nr = 3;
        if (nc < 0) nc = 0;
        if (nc > 3) nc = 3;
        v = (9*s[sr][sc] + 3*s[sr][nc] + 3*s[nr][sc] + s[nr][nc] + 8) / 16;
`else
        v = s[r/2][c/2];
`endif
        o[(r*8 + c)*8 +: 8] = v[7:0];
      end
    end
    return o;
  endfunction

  function automatic int pix(input logic [VW-1:0] v, input int r, input int c);
    return int'(v[(r*8 + c)*8 +: 8]);
  endfunction

  // Compare process: mid-cycle, after the driver has set this cycle's inputs.
  always begin
    @(negedge Clock);
    #1;
    if (!reset) begin
      busy = 1'b0;
      got_valid = 1'b0;
      chk_vec("rst_cb_u", u_if.Cb_u, '0);
      chk_vec("rst_cr_u", u_if.Cr_u, '0);
      chk_int("rst_out_valid", int'(u_if.out_valid), 0);
      chk_int("rst_in_ready", int'(u_if.in_ready), 1);
    end else begin
      chk_int("in_ready", int'(u_if.in_ready), busy ? 0 : 1);
      if (u_if.out_valid) begin
        if (!busy) begin
          chk_int("spurious_out_valid", 1, 0);
        end else begin
          if (!got_valid) chk_int("latency_enabled_cycles", en_cnt, 9);
          got_valid = 1'b1;
          chk_vec("cb_u", u_if.Cb_u, exp_cb);
          chk_vec("cr_u", u_if.Cr_u, exp_cr);
        end
      end else if (got_valid) begin
        chk_int("out_valid_dropped", 0, 1);
      end
      if (Enable) begin
        if (!busy && u_if.in_valid) begin
          exp_cb = model(u_if.Cb_d);
          exp_cr = model(u_if.Cr_d);
          busy = 1'b1;
          got_valid = 1'b0;
          en_cnt = 1;
        end else if (busy && got_valid && u_if.out_ready) begin
          busy = 1'b0;
          got_valid = 1'b0;
        end else if (busy && !got_valid) begin
          en_cnt++;
        end
      end
    end
  end

  task automatic step();
    @(negedge Clock);
    if (rand_mode) begin
      Enable = ($urandom_range(0, 3) != 0);
      u_if.out_ready = ($urandom_range(0, 1) == 1);
    end
  endtask

  task automatic send(input logic [VW-1:0] cb, input logic [VW-1:0] cr, output int cap);
    int g;
    g = 0;
    u_if.in_valid = 1'b1;
    u_if.Cb_d = cb;
    u_if.Cr_d = cr;
    while (!(u_if.in_ready && Enable) && g < 300) begin
      step();
      g++;
    end
    if (g >= 300) chk_int("send_timeout", g, 0);
    cap = cyc;
    step();
    u_if.in_valid = 1'b0;
    u_if.Cb_d = rand_vec();
    u_if.Cr_d = rand_vec();
  endtask

  task automatic wait_valid(output int seen);
    int g;
    g = 0;
    while (!u_if.out_valid && g < 300) begin
      step();
      g++;
    end
    if (g >= 300) chk_int("out_valid_timeout", g, 0);
    seen = cyc;
  endtask

  task automatic release_blk();
    int g;
    g = 0;
    if (!rand_mode) u_if.out_ready = 1'b1;
    while (!(u_if.out_valid && u_if.out_ready && Enable) && g < 300) begin
      step();
      g++;
    end
    if (g >= 300) chk_int("release_timeout", g, 0);
    step();
    if (!rand_mode) u_if.out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] v80, v40, vff, v3, ma, mb, tmp;
    int cap, seen, hs;

    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b0;
    u_if.Cb_d = '0;
    u_if.Cr_d = '0;
    v80 = {64{8'h80}};
    v40 = {64{8'h40}};
    vff = {64{8'hFF}};
    v3  = '0;
    v3[(0*8+0)*8 +: 8] = 8'd10;
    v3[(0*8+1)*8 +: 8] = 8'd10;
    v3[(1*8+0)*8 +: 8] = 8'd10;
    v3[(1*8+1)*8 +: 8] = 8'd10;

    // model pins (hand-computed)
    tmp = model(v80);
    chk_vec("pin_model_flat", tmp, v80);
    tmp = model(v3);
`ifdef BILINEAR_INTERP_EN
    chk_int("pin_model_11", pix(tmp, 1, 1), 6);
    chk_int("pin_model_22", pix(tmp, 2, 2), 1);
`else
    chk_int("pin_model_11", pix(tmp, 1, 1), 10);
    chk_int("pin_model_22", pix(tmp, 2, 2), 0);
`endif

    // reset state
    repeat (3) step();
    reset = 1'b1;
    Enable = 1'b1;
    step();
    chk_int("reset_in_ready", int'(u_if.in_ready), 1);
    chk_vec("reset_cb_u", u_if.Cb_u, '0);

    // flat block
    send(v80, v40, cap);
    wait_valid(seen);
    chk_int("t2_latency", seen - cap, 9);
    chk_vec("t2_cb", u_if.Cb_u, v80);
    chk_vec("t2_cr", u_if.Cr_u, v40);
    release_blk();

    // single-sample block
    send(v3, '0, cap);
    wait_valid(seen);
    chk_int("t3_00", pix(u_if.Cb_u, 0, 0), 10);
`ifdef BILINEAR_INTERP_EN
    chk_int("t3_11", pix(u_if.Cb_u, 1, 1), 6);
    chk_int("t3_22", pix(u_if.Cb_u, 2, 2), 1);
`else
    chk_int("t3_11", pix(u_if.Cb_u, 1, 1), 10);
    chk_int("t3_22", pix(u_if.Cb_u, 2, 2), 0);
`endif
    chk_int("t3_77", pix(u_if.Cb_u, 7, 7), 0);
    release_blk();

    // saturated block
    send(vff, vff, cap);
    wait_valid(seen);
    chk_vec("t4_cb", u_if.Cb_u, vff);
    chk_vec("t4_cr", u_if.Cr_u, vff);
    release_blk();

    // back-pressure with a second block waiting
    ma = rand_vec();
    mb = rand_vec();
    send(ma, mb, cap);
    wait_valid(seen);
    u_if.in_valid = 1'b1;
    u_if.Cb_d = mb;
    u_if.Cr_d = ma;
    repeat (5) begin
      step();
      chk_int("t5_in_ready_low", int'(u_if.in_ready), 0);
      chk_int("t5_out_valid_held", int'(u_if.out_valid), 1);
    end
    u_if.out_ready = 1'b1;
    hs = cyc;
    step();
    u_if.out_ready = 1'b0;
    send(mb, ma, cap);
    chk_int("t5_capture_after_hs", cap - hs, 1);
    wait_valid(seen);
    chk_vec("t5_cb", u_if.Cb_u, model(mb));
    release_blk();

    // Enable stall at row 4
    send(v80, v40, cap);
    repeat (4) step();
    Enable = 1'b0;
    repeat (3) step();
    Enable = 1'b1;
    wait_valid(seen);
    chk_int("t6_latency_stall", seen - cap, 12);
    chk_vec("t6_cb", u_if.Cb_u, v80);
    chk_vec("t6_cr", u_if.Cr_u, v40);
    release_blk();

    // reset pulse at row 4
    send(vff, vff, cap);
    repeat (4) step();
    reset = 1'b0;
    step();
    chk_vec("t6r_cb_zero", u_if.Cb_u, '0);
    chk_int("t6r_in_ready", int'(u_if.in_ready), 1);
    chk_int("t6r_out_valid", int'(u_if.out_valid), 0);
    reset = 1'b1;
    step();
    ma = rand_vec();
    send(ma, v40, cap);
    wait_valid(seen);
    chk_int("t6r_latency", seen - cap, 9);
    chk_vec("t6r_cb", u_if.Cb_u, model(ma));
    release_blk();

    // randomized blocks with random Enable / out_ready
    rand_mode = 1'b1;
    for (int k = 0; k < 25; k++) begin
      send(rand_vec(), rand_vec(), cap);
      wait_valid(seen);
      release_blk();
    end
    rand_mode = 1'b0;
    Enable = 1'b1;
    u_if.out_ready = 1'b0;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
